gray_counter_param: RTL and testbench

Parametrised, registered up/down Gray-code counter with synchronous load, clear and wrap/saturate mode. Successor to the combinational 4-bit binary-to-Gray converter: it keeps an internal binary count, drives both the binary and the Gray encoding from registers, and flags boundary events. It is used wherever a glitch-free, single-bit-change count is needed, such as position encoders and pointers crossing clock domains.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/gray_counter_param_conversor.sv | 13 +
 rtl/gray_counter_param.sv | 88 ++++++++
 tb/tb_gray_counter_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 64;
  localparam int unsigned MODE_WRAP  = 1;
  localparam int unsigned MODE_SAT   = 0;

  // Narrower values are zero-extended by the caller; leading zeros encode to zeros.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_param_conversor.sv
// Combinational WIDTH-bit binary-to-Gray converter.
module conversor_bin_gray_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray_c
);

  assign o_gray_c = WIDTH'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_counter_param.sv
// Registered up/down Gray counter with load, clear and wrap/saturate limit handling.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAP  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] binario_in,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] binario,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             no_limite
);

  localparam int unsigned WP1 = WIDTH + 1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_lim;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;
  logic             w_next_lim;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  // The extra MSB is the carry (up) or borrow (down) that marks a limit crossing.
  assign w_inc = WP1'(r_bin) + WP1'(1);
  assign w_dec = WP1'(r_bin) - WP1'(1);

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (clr) begin
      w_next_bin = '0;
    end else if (load) begin
      w_next_bin = binario_in;
    end else if (en) begin
      if (up_down) begin
        w_next_wrap = w_inc[WIDTH];
        if (!w_inc[WIDTH] || (WRAP == MODE_WRAP)) begin
          w_next_bin = w_inc[WIDTH-1:0];
        end
      end else begin
        w_next_wrap = w_dec[WIDTH];
        if (!w_dec[WIDTH] || (WRAP == MODE_WRAP)) begin
          w_next_bin = w_dec[WIDTH-1:0];
        end
      end
    end
    w_next_lim = up_down ? (&w_next_bin) : ~(|w_next_bin);
  end

  conversor_bin_gray_param #(
    .WIDTH(WIDTH)
  ) u_conv (
    .i_bin    (w_next_bin),
    .o_gray_c (w_next_gray)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
      r_lim  <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
      r_lim  <= w_next_lim;
    end
  end

  assign binario   = r_bin;
  assign gray      = r_gray;
  assign wrap      = r_wrap;
  assign no_limite = r_lim;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed scoreboard bench: 4-bit wrap, 4-bit saturate and 8-bit wrap counters on shared stimulus.
module tb_gray_counter_param;
  import gray_pkg::*;

  typedef struct {
    int         idx;
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
    logic       lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, clr, load, en, up_down;
  logic [3:0] bin_in4;
  logic [7:0] bin_in8;

  logic [3:0] b_4w, g_4w, b_4s, g_4s;
  logic [7:0] b_8w, g_8w;
  logic       w_4w, l_4w, w_4s, l_4s, w_8w, l_8w;

  int         n_vec = 0;
  int         n_err = 0;
  int unsigned m_cnt [3];
  exp_t       sb_q[$];

  logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .WRAP(MODE_WRAP)) u_4w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .binario_in(bin_in4),
    .en(en), .up_down(up_down), .binario(b_4w), .gray(g_4w), .wrap(w_4w), .no_limite(l_4w));

  gray_counter_param #(.WIDTH(4), .WRAP(MODE_SAT)) u_4s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .binario_in(bin_in4),
    .en(en), .up_down(up_down), .binario(b_4s), .gray(g_4s), .wrap(w_4s), .no_limite(l_4s));

  gray_counter_param #(.WIDTH(8), .WRAP(MODE_WRAP)) u_8w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .binario_in(bin_in8),
    .en(en), .up_down(up_down), .binario(b_8w), .gray(g_8w), .wrap(w_8w), .no_limite(l_8w));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one counter instance for the inputs currently driven.
  task automatic model(input int k, output exp_t e);
    int unsigned maxv;
    int unsigned w;
    logic        wr;
    w    = (k == 2) ? 8 : 4;
    maxv = (1 << w) - 1;
    wr   = 1'b0;
    if (!rst_n) begin
      m_cnt[k] = 0;
    end else if (clr) begin
      m_cnt[k] = 0;
    end else if (load) begin
      m_cnt[k] = (k == 2) ? int'(bin_in8) : int'(bin_in4);
    end else if (en && up_down) begin
      if (m_cnt[k] == maxv) begin
        wr = 1'b1;
        m_cnt[k] = (k == 1) ? maxv : 0;
      end else m_cnt[k] = m_cnt[k] + 1;
    end else if (en) begin
      if (m_cnt[k] == 0) begin
        wr = 1'b1;
        m_cnt[k] = (k == 1) ? 0 : maxv;
      end else m_cnt[k] = m_cnt[k] - 1;
    end
    e.idx  = k;
    e.bin  = 8'(m_cnt[k]);
    e.gray = 8'(m_cnt[k] ^ (m_cnt[k] >> 1));
    e.wrap = wr;
    e.lim  = !rst_n ? 1'b0 : (up_down ? (m_cnt[k] == maxv) : (m_cnt[k] == 0));
  endtask

  // Push expectations, clock once, then pop and compare each instance.
  task automatic tick();
    exp_t e;
    logic [7:0] ob, og;
    logic       ow, ol;
    for (int k = 0; k < 3; k++) begin
      model(k, e);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.idx)
        0:       begin ob = {4'h0, b_4w}; og = {4'h0, g_4w}; ow = w_4w; ol = l_4w; end
        1:       begin ob = {4'h0, b_4s}; og = {4'h0, g_4s}; ow = w_4s; ol = l_4s; end
        default: begin ob = b_8w;         og = g_8w;         ow = w_8w; ol = l_8w; end
      endcase
      check($sformatf("bin[%0d]", e.idx), ob, e.bin);
      check($sformatf("gray[%0d]", e.idx), og, e.gray);
      check($sformatf("wrap[%0d]", e.idx), {7'h0, ow}, {7'h0, e.wrap});
      check($sformatf("lim[%0d]", e.idx), {7'h0, ol}, {7'h0, e.lim});
    end
  endtask

  initial begin
    logic [3:0] p4;
    logic [7:0] p8;
    // Reset held with competing controls active
    rst_n = 1'b0; clr = 1'b0; load = 1'b1; en = 1'b1; up_down = 1'b1;
    bin_in4 = 4'b1010; bin_in8 = 8'hAA;
    tick();
    tick();
    check("rst_bin", {4'h0, b_4w}, 8'h00);
    check("rst_wrap", {7'h0, w_4w}, 8'h00);

    // Release: first edge counts normally
    rst_n = 1'b1; load = 1'b0;
    tick();
    check("rel_bin", {4'h0, b_4w}, 8'h01);
    check("rel_gray", {4'h0, g_4w}, 8'h01);

    // Full up sweep from 0
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      p4 = g_4w;
      tick();
      check($sformatf("seq_gray%0d", i), {4'h0, g_4w}, {4'h0, gseq[i % 16]});
      check($sformatf("seq_1bit%0d", i), 8'($countones(g_4w ^ p4)), 8'd1);
      check($sformatf("seq_wrap%0d", i), {7'h0, w_4w}, (i == 16) ? 8'h01 : 8'h00);
    end

    // Down from zero: wrap vs saturate
    clr = 1'b1; tick(); clr = 1'b0;
    up_down = 1'b0;
    tick();
    check("dn_bin_w", {4'h0, b_4w}, 8'h0F);
    check("dn_gray_w", {4'h0, g_4w}, 8'h08);
    check("dn_wrap_w", {7'h0, w_4w}, 8'h01);
    check("dn_bin_s", {4'h0, b_4s}, 8'h00);
    check("dn_wrap_s", {7'h0, w_4s}, 8'h01);
    check("dn_lim_s", {7'h0, l_4s}, 8'h01);
    tick();
    check("dn2_bin_w", {4'h0, b_4w}, 8'h0E);

    // Load at the limit beats enable; clear beats load
    up_down = 1'b1; en = 1'b0; load = 1'b1; bin_in4 = 4'hF; bin_in8 = 8'hFF;
    tick();
    en = 1'b1; bin_in4 = 4'b0101; bin_in8 = 8'h55;
    tick();
    check("ld_bin", {4'h0, b_4w}, 8'h05);
    check("ld_gray", {4'h0, g_4w}, 8'h07);
    check("ld_wrap", {7'h0, w_4w}, 8'h00);
    clr = 1'b1;
    tick();
    check("clr_bin", {4'h0, b_4w}, 8'h00);
    clr = 1'b0; load = 1'b0;

    // Reset in the middle of counting
    for (int i = 0; i < 6; i++) tick();
    check("mid_pre", {4'h0, b_4w}, 8'h06);
    rst_n = 1'b0;
    tick();
    check("mid_rst", {4'h0, b_4w}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("mid_restart", {4'h0, b_4w}, 8'h01);

    // 8-bit: wrap from all-ones, then a full sweep
    en = 1'b0; load = 1'b1; bin_in8 = 8'hFF; bin_in4 = 4'hF;
    tick();
    en = 1'b1; load = 1'b0;
    tick();
    check("w8_bin", b_8w, 8'h00);
    check("w8_wrap", {7'h0, w_8w}, 8'h01);
    for (int i = 0; i < 256; i++) begin
      p8 = g_8w;
      tick();
      check("w8_1bit", 8'($countones(g_8w ^ p8)), 8'd1);
      check("w8_b2g", g_8w, 8'(bin2gray(GRAY_MAX_W'(b_8w))));
      check("w8_g2b", 8'(gray2bin(GRAY_MAX_W'(g_8w))), b_8w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
